// File: rtl/sw_word_entry_pkg.sv
// Shared types and constants for the switch-driven 32-bit word entry block.
package sw_word_entry_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  typedef struct packed {
    state_t state;
    logic   load_level;
    logic   clr_level;
  } dbg_t;

endpackage

// File: rtl/sw_word_entry_btn_debounce.sv
// Two-flop synchroniser plus stability counter for one raw pushbutton.
// Emits a one-cycle rise pulse when the debounced level goes high.
module btn_debounce #(
  parameter int DEB_CYCLES = 1000000,
  parameter int DEB_W      = 20
) (
  input  logic clka,
  input  logic rsta,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [DEB_W-1:0] LAST = DEB_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [DEB_W-1:0] cnt;

  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      // Any sample matching the current level restarts the stability window.
      if (sync2 != level) begin
        if (cnt == LAST) begin
          level <= sync2;
          cnt   <= '0;
          rise  <= sync2;
        end else begin
          cnt <= cnt + DEB_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/sw_word_entry.sv
// Packs four operator-entered switch bytes into a 32-bit word (byte 0 first)
// and offers it to a consumer over a valid/ready handshake.
module sw_word_entry
  import sw_word_entry_pkg::*;
#(
  parameter int DEB_CYCLES = 1000000,
  parameter int DEB_W      = 20
) (
  input  logic                      clka,
  input  logic                      rsta,
  input  logic [BYTE_W-1:0]         SW,
  input  logic                      btn_load,
  input  logic                      btn_clr,
  output logic [BYTE_W*WORD_BYTES-1:0] douta,
  output logic                      valid,
  input  logic                      ready,
  output logic [1:0]                byte_idx,
  output logic                      busy,
  output dbg_t                      dbg
);

  localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

  logic load_level, load_rise;
  logic clr_level, clr_rise;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_load_deb (
    .clka (clka),
    .rsta (rsta),
    .raw  (btn_load),
    .level(load_level),
    .rise (load_rise)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_clr_deb (
    .clka (clka),
    .rsta (rsta),
    .raw  (btn_clr),
    .level(clr_level),
    .rise (clr_rise)
  );

  state_t                          state_q, state_n;
  logic [BYTE_W*WORD_BYTES-1:0]    douta_n;
  logic [1:0]                      idx_n;
  logic                            busy_n, valid_n;

  // Handshake: a word transfers on any rising edge where valid and ready are
  // both high; valid is registered and never depends combinationally on ready.
  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      state_q  <= COLLECT;
      douta    <= '0;
      byte_idx <= '0;
      busy     <= 1'b0;
      valid    <= 1'b0;
    end else begin
      state_q  <= state_n;
      douta    <= douta_n;
      byte_idx <= idx_n;
      busy     <= busy_n;
      valid    <= valid_n;
    end
  end

  always_comb begin
    state_n = state_q;
    douta_n = douta;
    idx_n   = byte_idx;
    busy_n  = busy;
    valid_n = valid;
    case (state_q)
      COLLECT: begin
        if (load_rise) begin
          case (byte_idx)
            2'd0:    douta_n = {{(BYTE_W*(WORD_BYTES-1)){1'b0}}, SW};
            2'd1:    douta_n[15:8]  = SW;
            2'd2:    douta_n[23:16] = SW;
            default: douta_n[31:24] = SW;
          endcase
          if (byte_idx == LAST_IDX) begin
            idx_n   = '0;
            busy_n  = 1'b0;
            valid_n = 1'b1;
            state_n = FULL;
          end else begin
            idx_n  = byte_idx + 2'd1;
            busy_n = 1'b1;
          end
        end
      end
      FULL: begin
        // Loads are dropped here; the word stays put after transfer as well.
        if (valid && ready) begin
          valid_n = 1'b0;
          state_n = COLLECT;
        end
      end
      default: state_n = COLLECT;
    endcase
    if (clr_rise) begin
      douta_n = '0;
      idx_n   = '0;
      busy_n  = 1'b0;
      valid_n = 1'b0;
      state_n = COLLECT;
    end
  end

  assign dbg = '{state: state_q, load_level: load_level, clr_level: clr_level};

endmodule

// File: tb/tb_sw_word_entry.sv
// Bench for sw_word_entry: button presses with random switch bytes, checked
// against a queue-based model of word assembly.
module tb_sw_word_entry;
  import sw_word_entry_pkg::*;

  logic        clka = 1'b0;
  logic        rsta = 1'b0;
  logic [7:0]  SW = 8'h00;
  logic        btn_load = 1'b0;
  logic        btn_clr = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] douta;
  logic        valid;
  logic [1:0]  byte_idx;
  logic        busy;
  dbg_t        dbg;

  int total = 0;
  int bad = 0;
  int xfer_cnt = 0;
  int valid_cycles = 0;

  logic [7:0]  m_bytes[$];
  logic [31:0] m_word = 32'h0;
  bit          m_valid = 1'b0;

  sw_word_entry #(.DEB_CYCLES(4), .DEB_W(3)) dut (
    .clka    (clka),
    .rsta    (rsta),
    .SW      (SW),
    .btn_load(btn_load),
    .btn_clr (btn_clr),
    .douta   (douta),
    .valid   (valid),
    .ready   (ready),
    .byte_idx(byte_idx),
    .busy    (busy),
    .dbg     (dbg)
  );

  always #5 clka = ~clka;

  always @(posedge clka) begin
    if (valid) valid_cycles++;
    if (valid && ready) xfer_cnt++;
  end

  function automatic void model_load(input logic [7:0] b);
    if (m_valid) return;
    m_bytes.push_back(b);
    m_word = 32'h0;
    foreach (m_bytes[i]) m_word = m_word | (32'(m_bytes[i]) << (8 * i));
    if (m_bytes.size() == 4) begin
      m_valid = 1'b1;
      m_bytes.delete();
    end
  endfunction

  function automatic void model_clear();
    m_bytes.delete();
    m_word  = 32'h0;
    m_valid = 1'b0;
  endfunction

  function automatic logic [35:0] model_out();
    return {m_word, m_valid, 2'(m_bytes.size()), m_bytes.size() != 0};
  endfunction

  task automatic press(input bit do_load, input bit do_clr, input logic [7:0] sw_val);
    @(negedge clka);
    SW       = sw_val;
    btn_load = do_load;
    btn_clr  = do_clr;
    repeat (10) @(negedge clka);
    btn_load = 1'b0;
    btn_clr  = 1'b0;
    repeat (8) @(negedge clka);
  endtask

  task automatic test_reset();
    logic [7:0] b;
    repeat (3) @(negedge clka);
    rsta = 1'b1;
    repeat (3) @(negedge clka);
    total++;
    if ({douta, valid, byte_idx, busy} !== 36'h0) begin
      bad++;
      $display("FAIL reset_idle got=%h exp=%h", {douta, valid, byte_idx, busy}, 36'h0);
    end
    b = 8'($urandom_range(1, 255));
    press(1'b1, 1'b0, b);
    model_load(b);
    total++;
    if ({douta, valid, byte_idx, busy} !== model_out()) begin
      bad++;
      $display("FAIL reset_pre_load got=%h exp=%h", {douta, valid, byte_idx, busy}, model_out());
    end
    @(negedge clka);
    #2 rsta = 1'b0;
    #1;
    total++;
    if ({douta, valid, byte_idx, busy} !== 36'h0) begin
      bad++;
      $display("FAIL reset_async got=%h exp=%h", {douta, valid, byte_idx, busy}, 36'h0);
    end
    model_clear();
    @(negedge clka);
    rsta = 1'b1;
    repeat (2) @(negedge clka);
  endtask

  task automatic test_debounce();
    logic [1:0] idx_at6, idx_at7;
    @(negedge clka);
    SW = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      btn_load = (i % 2 == 0);
      @(negedge clka);
    end
    btn_load = 1'b1;
    repeat (6) @(negedge clka);
    idx_at6 = byte_idx;
    @(negedge clka);
    idx_at7 = byte_idx;
    repeat (3) @(negedge clka);
    btn_load = 1'b0;
    repeat (8) @(negedge clka);
    model_load(8'hA5);
    total++;
    if (idx_at6 !== 2'd0 || idx_at7 !== 2'd1) begin
      bad++;
      $display("FAIL deb_latency got=%0d,%0d exp=0,1", idx_at6, idx_at7);
    end
    total++;
    if ({douta, valid, byte_idx, busy} !== {32'h000000A5, 1'b0, 2'd1, 1'b1}) begin
      bad++;
      $display("FAIL deb_single got=%h exp=%h", {douta, valid, byte_idx, busy}, {32'h000000A5, 1'b0, 2'd1, 1'b1});
    end
  endtask

  task automatic test_full_word();
    logic [7:0] sws[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    press(1'b0, 1'b1, 8'h00);
    model_clear();
    for (int i = 0; i < 4; i++) begin
      press(1'b1, 1'b0, sws[i]);
      model_load(sws[i]);
      total++;
      if ({douta, valid, byte_idx, busy} !== model_out()) begin
        bad++;
        $display("FAIL word_byte%0d got=%h exp=%h", i, {douta, valid, byte_idx, busy}, model_out());
      end
    end
    total++;
    if ({douta, valid, byte_idx, busy} !== {32'h44332211, 1'b1, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL word_full got=%h exp=%h", {douta, valid, byte_idx, busy}, {32'h44332211, 1'b1, 2'd0, 1'b0});
    end
    press(1'b1, 1'b0, 8'hFF);
    model_load(8'hFF);
    total++;
    if ({douta, valid, byte_idx, busy} !== model_out()) begin
      bad++;
      $display("FAIL word_drop got=%h exp=%h", {douta, valid, byte_idx, busy}, model_out());
    end
  endtask

  task automatic test_transfer();
    @(negedge clka);
    ready = 1'b1;
    @(negedge clka);
    ready = 1'b0;
    m_valid = 1'b0;
    total++;
    if ({douta, valid, byte_idx, busy} !== {32'h44332211, 1'b0, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL xfer_hold got=%h exp=%h", {douta, valid, byte_idx, busy}, {32'h44332211, 1'b0, 2'd0, 1'b0});
    end
    press(1'b1, 1'b0, 8'h77);
    model_load(8'h77);
    total++;
    if ({douta, valid, byte_idx, busy} !== {32'h00000077, 1'b0, 2'd1, 1'b1}) begin
      bad++;
      $display("FAIL xfer_newword got=%h exp=%h", {douta, valid, byte_idx, busy}, {32'h00000077, 1'b0, 2'd1, 1'b1});
    end
  endtask

  task automatic test_clear();
    logic [7:0] b;
    press(1'b0, 1'b1, 8'h00);
    model_clear();
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom_range(1, 255));
      press(1'b1, 1'b0, b);
      model_load(b);
    end
    total++;
    if ({douta, valid, byte_idx, busy} !== model_out()) begin
      bad++;
      $display("FAIL clr_pre got=%h exp=%h", {douta, valid, byte_idx, busy}, model_out());
    end
    press(1'b0, 1'b1, 8'h00);
    model_clear();
    total++;
    if ({douta, valid, byte_idx, busy} !== 36'h0) begin
      bad++;
      $display("FAIL clr_mid got=%h exp=%h", {douta, valid, byte_idx, busy}, 36'h0);
    end
    b = 8'($urandom_range(1, 255));
    press(1'b1, 1'b0, b);
    press(1'b1, 1'b1, 8'h5A);
    model_clear();
    total++;
    if ({douta, valid, byte_idx, busy} !== 36'h0) begin
      bad++;
      $display("FAIL clr_and_load got=%h exp=%h", {douta, valid, byte_idx, busy}, 36'h0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    @(negedge clka);
    ready = 1'b1;
    xfer_cnt = 0;
    valid_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      press(1'b1, 1'b0, b);
      model_load(b);
    end
    m_valid = 1'b0;
    ready = 1'b0;
    total++;
    if (valid_cycles != 1 || xfer_cnt != 1) begin
      bad++;
      $display("FAIL b2b_count got=%0d/%0d exp=1/1", valid_cycles, xfer_cnt);
    end
    total++;
    if ({douta, valid, byte_idx, busy} !== model_out()) begin
      bad++;
      $display("FAIL b2b_word got=%h exp=%h", {douta, valid, byte_idx, busy}, model_out());
    end
  endtask

  task automatic test_random();
    int op;
    logic [7:0] b;
    for (int i = 0; i < 12; i++) begin
      op = $urandom_range(0, 5);
      if (op <= 3) begin
        b = 8'($urandom);
        press(1'b1, 1'b0, b);
        model_load(b);
      end else if (op == 4) begin
        press(1'b0, 1'b1, 8'h00);
        model_clear();
      end else begin
        @(negedge clka);
        ready = 1'b1;
        @(negedge clka);
        ready = 1'b0;
        m_valid = 1'b0;
      end
      total++;
      if ({douta, valid, byte_idx, busy} !== model_out()) begin
        bad++;
        $display("FAIL rand_op%0d_%0d got=%h exp=%h", i, op, {douta, valid, byte_idx, busy}, model_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_full_word();
    test_transfer();
    test_clear();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
